// File: rtl/matrix_multiplier_nxn_if.sv
// Host-side bus of the NxN matrix multiplier: A/B element writes, multiply control and R readback.
interface matrix_multiplier_nxn_if #(
    parameter int unsigned N  = 3,
    parameter int unsigned DW = 3,
    parameter int unsigned RW = 8
);
    localparam int unsigned IW = (N < 2) ? 1 : $clog2(N);

    logic          start;
    logic          mode;
    logic          wr_en;
    logic          wr_sel;
    logic [IW-1:0] wr_row;
    logic [IW-1:0] wr_col;
    logic [DW-1:0] wr_data;
    logic [IW-1:0] rd_row;
    logic [IW-1:0] rd_col;
    logic [RW-1:0] rd_data;
    logic          busy;
    logic          done;

    // Host side drives control and indices, receives status and read data.
    modport master (
        output start, mode, wr_en, wr_sel, wr_row, wr_col, wr_data, rd_row, rd_col,
        input  rd_data, busy, done
    );

    // Multiplier side.
    modport slave (
        input  start, mode, wr_en, wr_sel, wr_row, wr_col, wr_data, rd_row, rd_col,
        output rd_data, busy, done
    );
endinterface

// File: rtl/matrix_multiplier_nxn.sv
// Sequential NxN matrix multiplier: R = A*B or R = R + A*B, one multiply-accumulate per cycle.
// The loop runs k innermost, then col, then row; each R element is written when k reaches N-1.
module matrix_multiplier_nxn #(
    parameter int unsigned N  = 3,
    parameter int unsigned DW = 3,
    parameter int unsigned RW = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    matrix_multiplier_nxn_if.slave bus
);
    localparam int unsigned IW      = (N < 2) ? 1 : $clog2(N);
    localparam logic [IW:0]   LP_N    = (IW + 1)'(N);
    localparam logic [IW-1:0] LP_LAST = IW'(N - 1);

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e          r_state;
    logic [IW-1:0]   r_row;
    logic [IW-1:0]   r_col;
    logic [IW-1:0]   r_k;
    logic [RW-1:0]   r_acc;
    logic            r_mode;
    logic            r_busy;
    logic            r_done;
    logic [RW-1:0]   r_rd_data;

    logic [DW-1:0]   r_a [N][N];
    logic [DW-1:0]   r_b [N][N];
    logic [RW-1:0]   r_r [N][N];

    logic [2*DW-1:0] w_prod;
    logic [RW-1:0]   w_prod_rw;
    logic [RW-1:0]   w_base;
    logic [RW-1:0]   w_acc_next;
    logic            w_k_last;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_wr_ok;
    logic            w_rd_ok;
    logic            w_r_wr;

    // MAC datapath and index decode.
    always_comb begin
        w_prod     = (2 * DW)'(r_a[r_row][r_k]) * (2 * DW)'(r_b[r_k][r_col]);
        // Product is zero-extended or truncated to the result width; sums wrap.
        w_prod_rw  = RW'(w_prod);
        if (r_k != '0) begin
            w_base = r_acc;
        end else if (r_mode) begin
            w_base = r_r[r_row][r_col];
        end else begin
            w_base = '0;
        end
        w_acc_next = w_base + w_prod_rw;
        w_k_last   = (r_k == LP_LAST);
        w_col_last = (r_col == LP_LAST);
        w_row_last = (r_row == LP_LAST);
        w_r_wr     = (r_state == StMac) && w_k_last;
        // Host writes are only accepted in IDLE and only for in-range indices.
        w_wr_ok    = (r_state == StIdle) && bus.wr_en &&
                     ({1'b0, bus.wr_row} < LP_N) && ({1'b0, bus.wr_col} < LP_N);
        w_rd_ok    = ({1'b0, bus.rd_row} < LP_N) && ({1'b0, bus.rd_col} < LP_N);
    end

    // Control FSM with loop counters, accumulator and registered busy/done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // A start arriving while busy never reaches this branch, so it is dropped.
                    if (bus.start) begin
                        r_state <= StMac;
                        r_mode  <= bus.mode;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StMac: begin
                    r_acc <= w_acc_next;
                    if (w_k_last) begin
                        r_k <= '0;
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row   <= '0;
                                r_state <= StDone;
                                r_done  <= 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand storage, written from the host port in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                for (int j = 0; j < int'(N); j++) begin
                    r_a[i][j] <= '0;
                    r_b[i][j] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            if (bus.wr_sel) begin
                r_b[bus.wr_row][bus.wr_col] <= bus.wr_data;
            end else begin
                r_a[bus.wr_row][bus.wr_col] <= bus.wr_data;
            end
        end
    end

    // Result storage, written once per element on its last k step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                for (int j = 0; j < int'(N); j++) begin
                    r_r[i][j] <= '0;
                end
            end
        end else if (w_r_wr) begin
            r_r[r_row][r_col] <= w_acc_next;
        end
    end

    // Registered readback; out-of-range indices read as zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (w_rd_ok) begin
            r_rd_data <= r_r[bus.rd_row][bus.rd_col];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign bus.rd_data = r_rd_data;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_matrix_multiplier_nxn.sv
// Directed, table-driven bench for matrix_multiplier_nxn at N=3, DW=3, RW=8.
module tb_matrix_multiplier_nxn;
    logic clk;
    logic rst_n;
    int   n_err;
    int   n_checks;

    matrix_multiplier_nxn_if #(.N(3), .DW(3), .RW(8)) bus ();

    matrix_multiplier_nxn #(.N(3), .DW(3), .RW(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        int         exp;
    } rd_vec_t;

    rd_vec_t tbl_b [9];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wr(input logic sel, input logic [1:0] r, input logic [1:0] c,
                      input logic [2:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = r;
        bus.wr_col  = c;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] r, input logic [1:0] c, output int v);
        bus.rd_row = r;
        bus.rd_col = c;
        @(negedge clk);
        v = int'(bus.rd_data);
    endtask

    // A = identity, B[i][j] = (3i+j) mod 8.
    task automatic load_ident();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                wr(1'b0, 2'(i), 2'(j), (i == j) ? 3'd1 : 3'd0);
                wr(1'b1, 2'(i), 2'(j), 3'((3 * i + j) % 8));
            end
        end
    endtask

    task automatic load_all7();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                wr(1'b0, 2'(i), 2'(j), 3'd7);
                wr(1'b1, 2'(i), 2'(j), 3'd7);
            end
        end
    endtask

    task automatic check_tbl(input string name);
        int v;
        for (int i = 0; i < 9; i++) begin
            rd(tbl_b[i].row, tbl_b[i].col, v);
            check(name, v, tbl_b[i].exp);
        end
    endtask

    task automatic check_all(input string name, input int exp);
        int v;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rd(2'(i), 2'(j), v);
                check(name, v, exp);
            end
        end
    endtask

    // Start a multiply and observe a fixed 60-cycle window.
    // inj: 0 none, 1 write A[0][0]=5 at cycle 5, 2 start again at cycle 10,
    //      3 write A[1][1]=2 on the start edge.
    task automatic run(input logic m, input int inj, output int done_at, output int n_done,
                       output int last_busy);
        done_at   = 0;
        n_done    = 0;
        last_busy = 0;
        bus.start = 1'b1;
        bus.mode  = m;
        if (inj == 3) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b0;
            bus.wr_row  = 2'd1;
            bus.wr_col  = 2'd1;
            bus.wr_data = 3'd2;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        for (int cnt = 1; cnt <= 60; cnt++) begin
            if (bus.done) begin
                n_done++;
                if (done_at == 0) done_at = cnt;
            end
            if (bus.busy) last_busy = cnt;
            if (inj == 1 && cnt == 5) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_row  = 2'd0;
                bus.wr_col  = 2'd0;
                bus.wr_data = 3'd5;
            end
            if (inj == 1 && cnt == 6) bus.wr_en = 1'b0;
            if (inj == 2 && cnt == 10) begin
                bus.start = 1'b1;
                bus.mode  = 1'b1;
            end
            if (inj == 2 && cnt == 11) bus.start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_timing(input string name, input int done_at, input int n_done,
                                input int last_busy);
        check({name, "_done_at"}, done_at, 28);
        check({name, "_n_done"}, n_done, 1);
        check({name, "_busy_last"}, last_busy, 28);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int d_at;
        int nd;
        int lb;

        n_err    = 0;
        n_checks = 0;
        tbl_b = '{
            '{2'd0, 2'd0, 0}, '{2'd0, 2'd1, 1}, '{2'd0, 2'd2, 2},
            '{2'd1, 2'd0, 3}, '{2'd1, 2'd1, 4}, '{2'd1, 2'd2, 5},
            '{2'd2, 2'd0, 6}, '{2'd2, 2'd1, 7}, '{2'd2, 2'd2, 0}
        };

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.mode    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = 2'd0;
        bus.wr_col  = 2'd0;
        bus.wr_data = 3'd0;
        bus.rd_row  = 2'd0;
        bus.rd_col  = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_rd_data", int'(bus.rd_data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("rst_r", 0);

        // Identity times B gives B.
        load_ident();
        run(1'b0, 0, d_at, nd, lb);
        check_timing("ident", d_at, nd, lb);
        check_tbl("ident_r");

        // All sevens: 3*49 = 147, then accumulate to 294 mod 256 = 38.
        load_all7();
        run(1'b0, 0, d_at, nd, lb);
        check_timing("all7", d_at, nd, lb);
        check_all("all7_r", 147);
        run(1'b1, 0, d_at, nd, lb);
        check_timing("acc", d_at, nd, lb);
        check_all("acc_r", 38);

        // Write while busy must be dropped; rerun shows A still identity.
        load_ident();
        run(1'b0, 1, d_at, nd, lb);
        check_timing("wr_busy", d_at, nd, lb);
        check_tbl("wr_busy_r");
        run(1'b0, 0, d_at, nd, lb);
        check_tbl("wr_busy_rerun_r");

        // Second start while busy is ignored, not queued.
        run(1'b0, 2, d_at, nd, lb);
        check_timing("start_busy", d_at, nd, lb);
        check_tbl("start_busy_r");

        // Write and start on the same edge: multiply sees A[1][1]=2.
        run(1'b0, 3, d_at, nd, lb);
        check_timing("wr_start", d_at, nd, lb);
        rd(2'd1, 2'd0, v); check("wr_start_r10", v, 6);
        rd(2'd1, 2'd1, v); check("wr_start_r11", v, 8);
        rd(2'd1, 2'd2, v); check("wr_start_r12", v, 10);
        rd(2'd0, 2'd1, v); check("wr_start_r01", v, 1);
        rd(2'd2, 2'd1, v); check("wr_start_r21", v, 7);

        // Out-of-range write and read indices.
        wr(1'b0, 2'd3, 2'd0, 3'd7);
        wr(1'b1, 2'd0, 2'd3, 3'd7);
        rd(2'd3, 2'd1, v); check("oor_rd_row", v, 0);
        rd(2'd1, 2'd3, v); check("oor_rd_col", v, 0);
        run(1'b0, 0, d_at, nd, lb);
        rd(2'd1, 2'd0, v); check("oor_wr_r10", v, 6);
        rd(2'd0, 2'd1, v); check("oor_wr_r01", v, 1);
        rd(2'd2, 2'd1, v); check("oor_wr_r21", v, 7);

        // Reset mid-multiply at cycle 12 aborts immediately.
        load_ident();
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cnt = 1; cnt < 12; cnt++) @(negedge clk);
        check("pre_rst_busy", int'(bus.busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_done", int'(bus.done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        lb = 0;
        for (int cnt = 0; cnt < 40; cnt++) begin
            if (bus.done) nd++;
            if (bus.busy) lb++;
            @(negedge clk);
        end
        check("post_rst_no_done", nd, 0);
        check("post_rst_no_busy", lb, 0);
        check_all("post_rst_r", 0);
        load_ident();
        run(1'b0, 0, d_at, nd, lb);
        check_timing("post_rst", d_at, nd, lb);
        check_tbl("post_rst_r2");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
